// File: rtl/blink_rtc.sv
// Real-time clock for the blink controller: prescaler -> tick -> second -> minute
// counters, sticky status bits with a mask-driven interrupt, and a byte register port.
module blink_rtc #(
    parameter int TICK_DIV = 49152,
    parameter int TICK_MAX = 200,
    parameter int SEC_MAX  = 60,
    parameter int MIN_W    = 21
) (
    input  logic       mck,
    input  logic       rin_n,
    input  logic       restim,
    input  logic       wr_en,
    input  logic       rd_en,
    input  logic [2:0] addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    input  logic       int_en,
    output logic       int_n,
    output logic [2:0] tsta,
    output logic       t_flash,
    output logic       t_grey
);
    localparam int PW  = $clog2(TICK_DIV);
    localparam int T0W = $clog2(TICK_MAX);
    localparam int T1W = $clog2(SEC_MAX);

    logic [PW-1:0]    presc_q, presc_d;
    logic [T0W-1:0]   tim0_q, tim0_d;
    logic [T1W-1:0]   tim1_q, tim1_d;
    logic [MIN_W-1:0] timm_q, timm_d;
    logic [T1W-1:0]   shd_tim1_q, shd_tim1_d;
    logic [MIN_W-1:0] shd_timm_q, shd_timm_d;
    logic [2:0]       tsta_q, tsta_d;
    logic [2:0]       tmk_q, tmk_d;
    logic [7:0]       rdata_q, rdata_d;

    logic       tick_ev, sec_ev, min_ev;
    logic       rd_fire;
    logic [2:0] clr;
    logic [7:0] tim0_rd, tim1_rd;
    logic [23:0] timm_ext;
    logic       unused_wdata;

    assign unused_wdata = ^wdata[7:3];

    always_comb begin
        tick_ev = ~restim & (presc_q == PW'(TICK_DIV - 1));
        sec_ev  = tick_ev & (tim0_q == T0W'(TICK_MAX - 1));
        min_ev  = sec_ev & (tim1_q == T1W'(SEC_MAX - 1));
    end

    // Counter chain; restim pins every counter at zero and suppresses all events.
    always_comb begin
        presc_d = presc_q + PW'(1);
        tim0_d  = tim0_q;
        tim1_d  = tim1_q;
        timm_d  = timm_q;
        if (restim) begin
            presc_d = '0;
            tim0_d  = '0;
            tim1_d  = '0;
            timm_d  = '0;
        end else begin
            if (tick_ev) begin
                presc_d = '0;
                tim0_d  = sec_ev ? '0 : tim0_q + T0W'(1);
            end
            if (sec_ev) begin
                tim1_d = min_ev ? '0 : tim1_q + T1W'(1);
            end
            if (min_ev) begin
                timm_d = timm_q + MIN_W'(1);
            end
        end
    end

    always_comb begin
        rd_fire = rd_en & ~wr_en;
        clr     = (wr_en && addr == 3'd5) ? wdata[2:0] : 3'b000;
        // Set is OR-ed in after the clear so a coinciding event wins.
        tsta_d  = (tsta_q & ~clr) | {min_ev, sec_ev, tick_ev};
        tmk_d   = (wr_en && addr == 3'd6) ? wdata[2:0] : tmk_q;

        shd_tim1_d = shd_tim1_q;
        shd_timm_d = shd_timm_q;
        if (rd_fire && addr == 3'd0) begin
            shd_tim1_d = tim1_q;
            shd_timm_d = timm_q;
        end

        tim0_rd                 = '0;
        tim0_rd[T0W-1:0]        = tim0_q;
        tim1_rd                 = '0;
        tim1_rd[T1W-1:0]        = shd_tim1_q;
        timm_ext                = '0;
        timm_ext[MIN_W-1:0]     = shd_timm_q;

        rdata_d = rdata_q;
        if (rd_fire) begin
            case (addr)
                3'd0:    rdata_d = tim0_rd;
                3'd1:    rdata_d = tim1_rd;
                3'd2:    rdata_d = timm_ext[7:0];
                3'd3:    rdata_d = timm_ext[15:8];
                3'd4:    rdata_d = timm_ext[23:16];
                3'd5:    rdata_d = {5'b0, tsta_q};
                3'd6:    rdata_d = {5'b0, tmk_q};
                default: rdata_d = 8'h00;
            endcase
        end
    end

    always_ff @(posedge mck or negedge rin_n) begin
        if (!rin_n) begin
            presc_q    <= '0;
            tim0_q     <= '0;
            tim1_q     <= '0;
            timm_q     <= '0;
            shd_tim1_q <= '0;
            shd_timm_q <= '0;
            tsta_q     <= '0;
            tmk_q      <= '0;
            rdata_q    <= '0;
        end else begin
            presc_q    <= presc_d;
            tim0_q     <= tim0_d;
            tim1_q     <= tim1_d;
            timm_q     <= timm_d;
            shd_tim1_q <= shd_tim1_d;
            shd_timm_q <= shd_timm_d;
            tsta_q     <= tsta_d;
            tmk_q      <= tmk_d;
            rdata_q    <= rdata_d;
        end
    end

    assign rdata   = rdata_q;
    assign tsta    = tsta_q;
    assign int_n   = ~(int_en & |(tsta_q & tmk_q));
    assign t_flash = tim0_q[T0W-1];
    assign t_grey  = presc_q[PW-1];

endmodule

// File: tb/tb_blink_rtc.sv
// Directed bench for blink_rtc: a small-parameter instance plus a 21-bit minute
// counter instance sharing the same stimulus.
module tb_blink_rtc;
    logic       mck = 1'b0;
    logic       rin_n, restim, wr_en, rd_en, int_en;
    logic [2:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata, rdata21;
    logic       int_n, int_n21, t_flash, t_flash21, t_grey, t_grey21;
    logic [2:0] tsta, tsta21;

    int n_cmp = 0;
    int n_bad = 0;
    int unsigned cyc;
    logic [7:0] r_a, r_b;
    logic [2:0] saved;

    blink_rtc #(.TICK_DIV(4), .TICK_MAX(3), .SEC_MAX(2), .MIN_W(8)) u_rtc (
        .mck(mck), .rin_n(rin_n), .restim(restim), .wr_en(wr_en), .rd_en(rd_en),
        .addr(addr), .wdata(wdata), .rdata(rdata), .int_en(int_en), .int_n(int_n),
        .tsta(tsta), .t_flash(t_flash), .t_grey(t_grey)
    );

    blink_rtc #(.TICK_DIV(4), .TICK_MAX(3), .SEC_MAX(2), .MIN_W(21)) u_rtc21 (
        .mck(mck), .rin_n(rin_n), .restim(restim), .wr_en(wr_en), .rd_en(rd_en),
        .addr(addr), .wdata(wdata), .rdata(rdata21), .int_en(int_en), .int_n(int_n21),
        .tsta(tsta21), .t_flash(t_flash21), .t_grey(t_grey21)
    );

    always #5 mck = ~mck;

    always @(posedge mck or negedge rin_n) begin
        if (!rin_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    typedef struct {
        int         adv;
        logic [2:0] tsta;
        logic       grey;
        logic       flash;
    } tvec_t;

    typedef struct {
        logic [2:0] addr;
        logic [7:0] exp_main;
        logic [7:0] exp_21;
    } rvec_t;

    tvec_t tv[7];
    rvec_t rv_a[8];
    rvec_t rv_b[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge mck);
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        wr_en = 1'b1; addr = a; wdata = d;
        @(negedge mck);
        wr_en = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [7:0] r0, output logic [7:0] r1);
        rd_en = 1'b1; addr = a;
        @(negedge mck);
        rd_en = 1'b0;
        r0 = rdata;
        r1 = rdata21;
    endtask

    task automatic wait_phase(input int unsigned p);
        for (int i = 0; i < 8 && (cyc % 4) != p; i++) @(negedge mck);
        chk("phase_sync", cyc % 4, p);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // cumulative cycle counts after reset release: 0,3,4,8,11,12,24
        tv[0] = '{0,  3'b000, 1'b0, 1'b0};
        tv[1] = '{3,  3'b000, 1'b1, 1'b0};
        tv[2] = '{1,  3'b001, 1'b0, 1'b0};
        tv[3] = '{4,  3'b001, 1'b0, 1'b1};
        tv[4] = '{3,  3'b001, 1'b1, 1'b1};
        tv[5] = '{1,  3'b011, 1'b0, 1'b0};
        tv[6] = '{12, 3'b111, 1'b0, 1'b0};

        rv_a[0] = '{3'd0, 8'h00, 8'h00};
        rv_a[1] = '{3'd1, 8'h00, 8'h00};
        rv_a[2] = '{3'd2, 8'h01, 8'h01};
        rv_a[3] = '{3'd3, 8'h00, 8'h00};
        rv_a[4] = '{3'd4, 8'h00, 8'h00};
        rv_a[5] = '{3'd5, 8'h07, 8'h07};
        rv_a[6] = '{3'd6, 8'h00, 8'h00};
        rv_a[7] = '{3'd7, 8'h00, 8'h00};

        // snapshot taken on the tick that also rolls the minute counter
        rv_b[0] = '{3'd0, 8'h02, 8'h02};
        rv_b[1] = '{3'd1, 8'h01, 8'h01};
        rv_b[2] = '{3'd2, 8'h00, 8'hFF};
        rv_b[3] = '{3'd3, 8'h00, 8'hFF};
        rv_b[4] = '{3'd4, 8'h00, 8'h1F};
        rv_b[5] = '{3'd0, 8'h01, 8'h01};
        rv_b[6] = '{3'd1, 8'h00, 8'h00};
        rv_b[7] = '{3'd2, 8'h01, 8'h00};
        rv_b[8] = '{3'd4, 8'h00, 8'h00};

        rin_n = 1'b0; restim = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        int_en = 1'b0; addr = 3'd0; wdata = 8'h00;
        #1;
        chk("rst_rdata", rdata, 8'h00);
        chk("rst_tsta", tsta, 3'b000);
        chk("rst_int_n", int_n, 1'b1);
        @(negedge mck); @(negedge mck);
        rin_n = 1'b1;

        // free-running count from reset
        for (int i = 0; i < 7; i++) begin
            step(tv[i].adv);
            chk($sformatf("cnt%0d_tsta", i), tsta, tv[i].tsta);
            chk($sformatf("cnt%0d_grey", i), t_grey, tv[i].grey);
            chk($sformatf("cnt%0d_flash", i), t_flash, tv[i].flash);
            chk($sformatf("cnt%0d_int_n", i), int_n, 1'b1);
        end
        for (int i = 0; i < 8; i++) begin
            rd(rv_a[i].addr, r_a, r_b);
            chk($sformatf("rdA%0d_main", i), r_a, rv_a[i].exp_main);
            chk($sformatf("rdA%0d_w21", i), r_b, rv_a[i].exp_21);
        end

        // interrupt mask and status clear
        wr(3'd5, 8'h07);
        chk("clr_all_tsta", tsta, 3'b000);
        wr(3'd6, 8'h01);
        int_en = 1'b1;
        chk("irq_idle", int_n, 1'b1);
        wait_phase(3);
        chk("irq_pre_tick", int_n, 1'b1);
        step(1);
        chk("irq_tsta_set", tsta, 3'b011);
        chk("irq_fall", int_n, 1'b0);
        wr(3'd5, 8'h01);
        chk("irq_clr_tsta", tsta, 3'b010);
        chk("irq_rise", int_n, 1'b1);

        // set beats clear on the same bit
        rd(3'd6, r_a, r_b);
        chk("tmk_read", r_a, 8'h01);
        wr(3'd5, 8'h00);
        chk("clr_zero_noop", tsta, 3'b010);
        step(1);
        chk("tick_sets_again", tsta, 3'b011);
        wait_phase(3);
        wr(3'd5, 8'h01);
        chk("set_beats_clr", tsta[0], 1'b1);
        wr(3'd5, 8'h01);
        chk("clr_no_tick", tsta, 3'b010);

        // ignored writes and write-over-read priority
        wr(3'd0, 8'hFF);
        wr(3'd7, 8'hFF);
        rd(3'd6, r_a, r_b);
        chk("tmk_kept", r_a, 8'h01);
        rd(3'd7, r_a, r_b);
        chk("addr7_zero", r_a, 8'h00);
        wr_en = 1'b1; rd_en = 1'b1; addr = 3'd6; wdata = 8'h05;
        @(negedge mck);
        wr_en = 1'b0; rd_en = 1'b0;
        chk("wr_over_rd_hold", rdata, 8'h00);
        rd(3'd6, r_a, r_b);
        chk("wr_over_rd_tmk", r_a, 8'h05);

        // restim held for 10 cycles
        step(1);
        saved = tsta;
        chk("pre_restim_tsta_nz", (saved != 3'b000), 1'b1);
        restim = 1'b1;
        step(1);
        chk("restim_grey", t_grey, 1'b0);
        chk("restim_flash", t_flash, 1'b0);
        rd(3'd0, r_a, r_b);
        chk("restim_tim0", r_a, 8'h00);
        rd(3'd1, r_a, r_b);
        chk("restim_tim1", r_a, 8'h00);
        rd(3'd2, r_a, r_b);
        chk("restim_timm", r_a, 8'h00);
        chk("restim_tsta_kept", tsta, saved);
        wr(3'd5, 8'h07);
        step(4);
        chk("restim_tsta_cleared", tsta, 3'b000);
        restim = 1'b0;
        step(3);
        chk("post_restim_no_tick", tsta, 3'b000);
        chk("post_restim_grey", t_grey, 1'b1);
        step(1);
        chk("post_restim_tick", tsta, 3'b001);
        chk("post_restim_irq", int_n, 1'b0);

        // asynchronous reset pulse between edges
        rd(3'd6, r_a, r_b);
        chk("pre_rst_rdata", rdata, 8'h05);
        #2 rin_n = 1'b0;
        #1;
        chk("arst_rdata", rdata, 8'h00);
        chk("arst_rdata21", rdata21, 8'h00);
        chk("arst_tsta", tsta, 3'b000);
        chk("arst_int_n", int_n, 1'b1);
        chk("arst_grey_flash", {t_grey, t_flash}, 2'b00);
        #1 rin_n = 1'b1;
        force u_rtc21.timm_q = 21'h1FFFFF;
        #0 release u_rtc21.timm_q;

        // snapshot coherence across the 21-bit minute rollover
        for (int i = 0; i < 64 && cyc != 23; i++) @(negedge mck);
        chk("sync23", cyc, 23);
        for (int i = 0; i < 9; i++) begin
            rd(rv_b[i].addr, r_a, r_b);
            chk($sformatf("rdB%0d_main", i), r_a, rv_b[i].exp_main);
            chk($sformatf("rdB%0d_w21", i), r_b, rv_b[i].exp_21);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
